gps_acq_scheduler: RTL and testbench

//  Sequences one full gps_ack acquisition sweep (8 groups x 4 SVs x 1024 code phases) and reduces its result stream.

---
 rtl/gps_acq_scheduler.sv | 164 ++++++++++++++++
 tb/tb_gps_acq_scheduler.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/gps_acq_scheduler.sv
// gps_acq_scheduler: sequences one acquisition sweep, tracks per-lane code-phase peaks, queues per-SV results.
// Optional ACQ_SCHED_PEAK2_EN adds per-lane second-peak tracking reported on o_res_mag2.
module gps_acq_scheduler #(
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_GROUPS = 8,
    parameter int TMO_BITS   = 24
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [11:0] i_threshold,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_timeout,
    output logic        o_overflow,
    output logic        o_ack_start,
    input  logic        i_corr_complete,
    input  logic [9:0]  i_code_phase,
    input  logic [5:0]  i_sat0,
    input  logic [5:0]  i_sat1,
    input  logic [5:0]  i_sat2,
    input  logic [5:0]  i_sat3,
    input  logic [11:0] i_integ0,
    input  logic [11:0] i_integ1,
    input  logic [11:0] i_integ2,
    input  logic [11:0] i_integ3,
    output logic        o_res_valid,
    input  logic        i_res_ready,
    output logic [5:0]  o_res_sat,
    output logic [9:0]  o_res_phase,
    output logic [11:0] o_res_mag,
    output logic        o_res_det,
    output logic [11:0] o_res_mag2
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(NUM_GROUPS + 1);
    typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_FLUSH, S_FINISH, S_ERR} state_t;
    typedef struct packed {
        logic [5:0]  sat;
        logic [9:0]  ph;
        logic [11:0] mag;
        logic        det;
        logic [11:0] mag2;
    } ent_t;
    state_t             r_state, w_next;
    logic [11:0]        r_thr;
    logic [GW-1:0]      r_grp;
    logic [1:0]         r_lane;
    logic               r_cc_d, r_timeout, r_overflow;
    logic [TMO_BITS-1:0] r_wd;
    logic [11:0]        r_peak [4];
    logic [9:0]         r_ph [4];
    logic [5:0]         r_sat [4];
    ent_t               r_mem [FIFO_DEPTH];
    logic [AW:0]        r_wp, r_rp;
    logic [11:0]        w_integ [4];
    logic [5:0]         w_sat [4];
    logic [11:0]        w_m [4];
    logic [9:0]         w_p;
    logic [AW:0]        w_cnt;
    logic               w_edge, w_last, w_clr, w_upd, w_full, w_push, w_pop, w_wr;
    ent_t               w_ent, w_head;
    assign w_integ = '{i_integ0, i_integ1, i_integ2, i_integ3};
    assign w_sat   = '{i_sat0, i_sat1, i_sat2, i_sat3};
    assign w_edge  = i_corr_complete & ~r_cc_d;
    // code_phase has already advanced past the phase just evaluated
    assign w_p     = i_code_phase - 10'd1;
    assign w_last  = r_lane == 2'd3;
    assign w_upd   = (r_state == S_RUN) & w_edge;
    assign w_clr   = ((r_state == S_IDLE) & i_start) | ((r_state == S_FLUSH) & w_last);
    assign w_cnt   = r_wp - r_rp;
    assign w_full  = w_cnt == (AW+1)'(FIFO_DEPTH);
    assign w_push  = r_state == S_FLUSH;
    assign w_pop   = o_res_valid & i_res_ready;
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_head  = r_mem[r_rp[AW-1:0]];
    always_comb begin
        for (int l = 0; l < 4; l++)
            w_m[l] = w_integ[l] >= 12'd2048 ? w_integ[l] - 12'd2048 : 12'd2048 - w_integ[l];
    end
`ifdef ACQ_SCHED_PEAK2_EN
    logic [11:0] r_pk2 [4];
    logic [3:0]  w_far;
    logic [9:0]  w_d [4];
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            w_d[l]   = w_p - r_ph[l];
            w_far[l] = (w_d[l] != 10'd0) & (w_d[l] != 10'd1) & (w_d[l] != 10'd1023);
        end
    end
    always_ff @(posedge i_clk) begin
        for (int l = 0; l < 4; l++)
            if (!i_rst || w_clr) r_pk2[l] <= '0;
            else if (w_upd && w_far[l]) begin
                if (w_m[l] > r_peak[l]) begin
                    if (r_peak[l] > r_pk2[l]) r_pk2[l] <= r_peak[l];
                end else if (w_m[l] > r_pk2[l]) r_pk2[l] <= w_m[l];
            end
    end
    assign w_ent = '{sat: r_sat[r_lane], ph: r_ph[r_lane], mag: r_peak[r_lane],
                     det: r_peak[r_lane] >= r_thr, mag2: r_pk2[r_lane]};
`else
    assign w_ent = '{sat: r_sat[r_lane], ph: r_ph[r_lane], mag: r_peak[r_lane],
                     det: r_peak[r_lane] >= r_thr, mag2: 12'd0};
`endif
    always_ff @(posedge i_clk) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = i_start ? S_START : S_IDLE;
            S_START:  w_next = S_RUN;
            S_RUN:    w_next = (w_edge && i_code_phase == 10'd0) ? S_FLUSH : (&r_wd) ? S_ERR : S_RUN;
            S_FLUSH:  w_next = !w_last ? S_FLUSH : (r_grp + 1'b1 == GW'(NUM_GROUPS)) ? S_FINISH : S_RUN;
            default:  w_next = S_IDLE;
        endcase
    end
    always_comb begin
        o_busy      = (r_state == S_START) | (r_state == S_RUN) | (r_state == S_FLUSH);
        o_done      = r_state == S_FINISH;
        o_ack_start = r_state == S_START;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_thr <= '0; r_grp <= '0; r_lane <= '0; r_cc_d <= 1'b0; r_wd <= '0;
            r_timeout <= 1'b0; r_overflow <= 1'b0; r_wp <= '0; r_rp <= '0;
            for (int l = 0; l < 4; l++) begin
                r_peak[l] <= '0; r_ph[l] <= '0; r_sat[l] <= '0;
            end
        end else begin
            r_cc_d <= i_corr_complete;
            r_wd   <= (r_state == S_RUN && !w_edge) ? r_wd + 1'b1 : '0;
            if (r_state == S_IDLE && i_start) begin
                r_thr <= i_threshold; r_grp <= '0; r_timeout <= 1'b0; r_overflow <= 1'b0;
            end
            if (r_state == S_FLUSH) begin
                r_lane <= r_lane + 2'd1;
                if (w_last) r_grp <= r_grp + 1'b1;
            end
            if (r_state == S_ERR) r_timeout <= 1'b1;
            if (w_push && !w_wr) r_overflow <= 1'b1;
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            for (int l = 0; l < 4; l++)
                if (w_clr) begin
                    r_peak[l] <= '0; r_ph[l] <= '0;
                end else if (w_upd) begin
                    r_sat[l] <= w_sat[l];
                    if (w_m[l] > r_peak[l]) begin
                        r_peak[l] <= w_m[l]; r_ph[l] <= w_p;
                    end
                end
        end
    end
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wp[AW-1:0]] <= w_ent;
    end
    assign o_res_valid = w_cnt != '0;
    assign o_timeout   = r_timeout;
    assign o_overflow  = r_overflow;
    assign {o_res_sat, o_res_phase, o_res_mag, o_res_det, o_res_mag2} = o_res_valid ? w_head : '0;
endmodule

// File: tb/tb_gps_acq_scheduler.sv
// tb_gps_acq_scheduler: correlator model driving gps_acq_scheduler; results checked by a queue-based scoreboard.
module tb_gps_acq_scheduler;
    localparam int FD = 4, NG = 2, TB = 8;
    localparam logic [11:0] MAG2_L1 =
`ifdef ACQ_SCHED_PEAK2_EN
        12'd800;
`else
        12'd0;
`endif
    localparam logic [11:0] MAG2_L2 =
`ifdef ACQ_SCHED_PEAK2_EN
        12'd1000;
`else
        12'd0;
`endif
    logic clk = 0, rst = 0, start = 0, cc = 0, rdy = 0;
    logic [11:0] thr = 0;
    logic [9:0]  cp = 0;
    logic [5:0]  sat [4] = '{default: '0};
    logic [11:0] integ [4] = '{default: 12'd2048};
    logic busy, done, tmo, ovf, ack, rv, rdet;
    logic [5:0]  rsat;
    logic [9:0]  rph;
    logic [11:0] rmag, rmag2;
    gps_acq_scheduler #(.FIFO_DEPTH(FD), .NUM_GROUPS(NG), .TMO_BITS(TB)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_threshold(thr),
        .o_busy(busy), .o_done(done), .o_timeout(tmo), .o_overflow(ovf), .o_ack_start(ack),
        .i_corr_complete(cc), .i_code_phase(cp),
        .i_sat0(sat[0]), .i_sat1(sat[1]), .i_sat2(sat[2]), .i_sat3(sat[3]),
        .i_integ0(integ[0]), .i_integ1(integ[1]), .i_integ2(integ[2]), .i_integ3(integ[3]),
        .o_res_valid(rv), .i_res_ready(rdy), .o_res_sat(rsat), .o_res_phase(rph),
        .o_res_mag(rmag), .o_res_det(rdet), .o_res_mag2(rmag2));
    always #5 clk = ~clk;
    typedef struct {
        logic [5:0]  sat;
        logic [9:0]  ph;
        logic [11:0] mag;
        logic        det;
        logic [11:0] mag2;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int n_vec = 0, n_err = 0, n_done = 0, n_ack = 0;
    bit pat;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (done) n_done++;
        if (ack) n_ack++;
        if (rv && rdy) begin
            if (q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_result: got sat %0d with empty scoreboard", rsat);
            end else begin
                e = q.pop_front();
                chk("res_sat", rsat, e.sat);
                chk("res_phase", rph, e.ph);
                chk("res_mag", rmag, e.mag);
                chk("res_det", rdet, e.det);
                chk("res_mag2", rmag2, e.mag2);
            end
        end
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic expect_res(input int s, input int ph, input int mag, input bit det, input int mag2);
        q.push_back('{sat: 6'(s), ph: 10'(ph), mag: 12'(mag), det: det, mag2: 12'(mag2)});
    endtask
    function automatic logic [11:0] f_integ(input int g, input int l, input int p);
        if (!pat || g != 0) return 12'd2048;
        case (l)
            0: return p == 517 ? 12'd3000 : 12'd2048;
            1: return p == 100 ? 12'd3048 : p == 101 ? 12'd3038 : p == 600 ? 12'd2848 : 12'd2048;
            2: return p == 100 ? 12'd3048 : p == 900 ? 12'd1048 : 12'd2048;
            default: return 12'd2048;
        endcase
    endfunction
    task automatic run_group(input int g, input int n);
        for (int p = 0; p < n; p++) begin
            cp = 10'((p + 1) % 1024);
            for (int l = 0; l < 4; l++) begin
                sat[l] = 6'(g * 4 + l + 1);
                integ[l] = f_integ(g, l, p);
            end
            cc = 1; tick(1);
            cc = 0; tick(1);
        end
        if (n == 1024) tick(8);
    endtask
    task automatic pulse_start(input logic [11:0] t);
        thr = t; start = 1; tick(1);
        start = 0; thr = 12'd4095; tick(2);
    endtask
    task automatic wait_done(input int d0);
        for (int i = 0; i < 30 && n_done == d0; i++) tick(1);
        chk("done_pulses", n_done - d0, 1);
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout"}, tmo, 0);
        chk({tag, "_overflow"}, ovf, 0);
        chk({tag, "_ack_start"}, ack, 0);
        chk({tag, "_res_valid"}, rv, 0);
        chk({tag, "_res_word"}, {rsat, rph, rmag, rdet, rmag2}, 0);
    endtask
    initial begin
        int d0, a0, cyc;
        tick(3);
        chk_zero("reset");
        rst = 1; tick(1);
        // sweep 1: peaks, ties and threshold with a free-running consumer
        pat = 1; rdy = 1; a0 = n_ack; d0 = n_done;
        expect_res(1, 517, 952, 1, 0);
        expect_res(2, 100, 1000, 1, MAG2_L1);
        expect_res(3, 100, 1000, 1, MAG2_L2);
        expect_res(4, 0, 0, 0, 0);
        for (int l = 0; l < 4; l++) expect_res(5 + l, 0, 0, 0, 0);
        pulse_start(12'd500);
        start = 1; tick(1); start = 0;
        run_group(0, 1024);
        run_group(1, 1024);
        wait_done(d0);
        chk("s1_ack_pulses", n_ack - a0, 1);
        chk("s1_busy_after", busy, 0);
        chk("s1_overflow", ovf, 0);
        chk("s1_timeout", tmo, 0);
        tick(10);
        chk("s1_drained", q.size(), 0);
        // sweep 2: consumer stalled, threshold 0 so zero magnitude still detects
        pat = 0; rdy = 0; d0 = n_done;
        for (int l = 0; l < 4; l++) expect_res(1 + l, 0, 0, 1, 0);
        pulse_start(12'd0);
        run_group(0, 1024);
        chk("s2_full_no_overflow", ovf, 0);
        run_group(1, 1024);
        wait_done(d0);
        chk("s2_overflow", ovf, 1);
        chk("s2_valid_held", rv, 1);
        chk("s2_busy_after", busy, 0);
        rdy = 1; tick(10);
        chk("s2_drained", q.size(), 0);
        chk("s2_fifo_empty", rv, 0);
        // sweep 3: correlator stalls after 10 edges
        d0 = n_done;
        pulse_start(12'd100);
        chk("s3_overflow_cleared", ovf, 0);
        run_group(0, 10);
        cyc = 0;
        while (!tmo && cyc < 400) begin tick(1); cyc++; end
        chk("s3_timeout", tmo, 1);
        chk("s3_timeout_not_early", cyc >= 250, 1);
        chk("s3_idle_after", busy, 0);
        chk("s3_no_done", n_done - d0, 0);
        pulse_start(12'd100);
        chk("s4_timeout_cleared", tmo, 0);
        run_group(0, 3);
        rst = 0; tick(1);
        chk_zero("midrun_reset");
        rst = 1; a0 = n_ack;
        pulse_start(12'd100);
        tick(3);
        chk("s5_ack_pulses", n_ack - a0, 1);
        chk("s5_busy", busy, 1);
        chk("final_scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
